// File: rtl/settings_loader_if.sv
// BRAM read port between the settings loader (master) and the controller parameter BRAM (slave).
interface settings_loader_if;
  logic        rd_en;
  logic [7:0]  addr;
  logic [15:0] rd_data;

  modport master (output rd_en, output addr, input rd_data);
  modport slave  (input rd_en, input addr, output rd_data);
endinterface

// File: rtl/settings_loader.sv
// Settings structs shared with the datapath, and the loader that polls the parameter BRAM
// and commits each settings group atomically with a one-cycle update pulse.
package settings_loader_pkg;

  typedef struct packed {
    logic        update;
    logic        mode;
    logic [15:0] update_rate_intensity;
    logic [15:0] update_rate_phase;
    logic [15:0] completion_steps_intensity;
    logic [15:0] completion_steps_phase;
  } silencer_settings_t;

  typedef struct packed {
    logic        update;
    logic [31:0] ecat_sync_base_cnt;
    logic [63:0] ecat_sync_time;
  } sync_settings_t;

  typedef struct packed {
    logic        update;
    logic [15:0] full_width_start;
  } pulse_width_encoder_settings_t;

  typedef enum logic [1:0] {
    GRP_SILENCER = 2'd0,
    GRP_SYNC     = 2'd1,
    GRP_PWE      = 2'd2
  } group_e;

endpackage

module settings_loader
  import settings_loader_pkg::*;
#(
  parameter int unsigned BRAM_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  settings_loader_if.master             bram_if,
  output silencer_settings_t            silencer_settings_o,
  output sync_settings_t                sync_settings_o,
  output pulse_width_encoder_settings_t pwe_settings_o,
  output logic                          busy_o
);

  typedef enum logic [2:0] {
    POLL_ISSUE = 3'd0,
    POLL_WAIT  = 3'd1,
    DECIDE     = 3'd2,
    LOAD_ISSUE = 3'd3,
    LOAD_WAIT  = 3'd4,
    COMMIT     = 3'd5
  } state_e;

  localparam logic [2:0]  LAST_WAIT    = 3'(BRAM_LATENCY - 1);
  localparam int unsigned SHADOW_WORDS = 6;

  if (BRAM_LATENCY < 1 || BRAM_LATENCY > 4) begin : g_latency_check
    $error("settings_loader: BRAM_LATENCY must be in 1..4");
  end

  state_e      state_q, state_d;
  group_e      grp_q, grp_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  wait_q, wait_d;
  logic        rd_en_q, issue_d;
  logic [7:0]  addr_q, addr_d;
  logic [2:0]  snap_q;
  logic [2:0]  seen_q;
  logic [2:0]  pending;
  logic        wait_done;
  logic [15:0] shadow_q [SHADOW_WORDS];

  silencer_settings_t            sil_q;
  sync_settings_t                sync_q;
  pulse_width_encoder_settings_t pwe_q;

  function automatic logic [2:0] last_word(input group_e g);
    unique case (g)
      GRP_SILENCER: return 3'd4;
      GRP_SYNC:     return 3'd5;
      default:      return 3'd0;
    endcase
  endfunction

  // Group words live at 0x10/0x20/0x30 + index.
  function automatic logic [7:0] word_addr(input group_e g, input logic [2:0] idx);
    unique case (g)
      GRP_SILENCER: return {4'h1, 1'b0, idx};
      GRP_SYNC:     return {4'h2, 1'b0, idx};
      GRP_PWE:      return {4'h3, 1'b0, idx};
      default:      return 8'h00;
    endcase
  endfunction

  assign pending   = snap_q ^ seen_q;
  assign wait_done = (wait_q == LAST_WAIT);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d = state_q;
    grp_d   = grp_q;
    idx_d   = idx_q;
    wait_d  = '0;
    unique case (state_q)
      // Right after reset no read has been issued yet; spend one cycle raising RD_EN first.
      POLL_ISSUE: if (rd_en_q) state_d = POLL_WAIT;
      POLL_WAIT: begin
        if (wait_done) state_d = DECIDE;
        else           wait_d  = wait_q + 3'd1;
      end
      DECIDE: begin
        idx_d   = '0;
        state_d = LOAD_ISSUE;
        if      (pending[0]) grp_d = GRP_SILENCER;
        else if (pending[1]) grp_d = GRP_SYNC;
        else if (pending[2]) grp_d = GRP_PWE;
        else                 state_d = POLL_ISSUE;
      end
      LOAD_ISSUE: state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        if (!wait_done) begin
          wait_d = wait_q + 3'd1;
        end else if (idx_q == last_word(grp_q)) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = LOAD_ISSUE;
        end
      end
      COMMIT:  state_d = POLL_ISSUE;
      default: state_d = POLL_ISSUE;
    endcase
  end

  assign issue_d = (state_d == POLL_ISSUE) || (state_d == LOAD_ISSUE);
  assign addr_d  = (state_d == LOAD_ISSUE) ? word_addr(grp_d, idx_d) : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= POLL_ISSUE;
      grp_q   <= GRP_SILENCER;
      idx_q   <= '0;
      wait_q  <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= 8'h00;
      snap_q  <= '0;
      seen_q  <= '0;
      sil_q   <= '0;
      sync_q  <= '0;
      pwe_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      rd_en_q <= issue_d;
      if (issue_d) addr_q <= addr_d;

      if (state_q == POLL_WAIT && wait_done) snap_q <= bram_if.rd_data[2:0];

      sil_q.update  <= 1'b0;
      sync_q.update <= 1'b0;
      pwe_q.update  <= 1'b0;

      if (state_q == COMMIT) begin
        unique case (grp_q)
          GRP_SILENCER: begin
            sil_q <= '{update:                     1'b1,
                       mode:                       shadow_q[0][0],
                       update_rate_intensity:      shadow_q[1],
                       update_rate_phase:          shadow_q[2],
                       completion_steps_intensity: shadow_q[3],
                       completion_steps_phase:     shadow_q[4]};
            seen_q[0] <= snap_q[0];
          end
          GRP_SYNC: begin
            sync_q <= '{update:             1'b1,
                        ecat_sync_base_cnt: {shadow_q[1], shadow_q[0]},
                        ecat_sync_time:     {shadow_q[5], shadow_q[4], shadow_q[3], shadow_q[2]}};
            seen_q[1] <= snap_q[1];
          end
          GRP_PWE: begin
            pwe_q <= '{update: 1'b1, full_width_start: shadow_q[0]};
            seen_q[2] <= snap_q[2];
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the shadow array has no reset; it only reaches the outputs through a completed COMMIT.
  always_ff @(posedge clk) begin
    if (state_q == LOAD_WAIT && wait_done) shadow_q[idx_q] <= bram_if.rd_data;
  end

  assign bram_if.rd_en = rd_en_q;
  assign bram_if.addr  = addr_q;

  assign silencer_settings_o = sil_q;
  assign sync_settings_o     = sync_q;
  assign pwe_settings_o      = pwe_q;
  assign busy_o = (state_q == LOAD_ISSUE) || (state_q == LOAD_WAIT) || (state_q == COMMIT);

endmodule

// File: tb/tb_settings_loader.sv
// Directed bench for settings_loader: BRAM model, expected-commit scoreboard and an update monitor.
module tb_settings_loader;
  import settings_loader_pkg::*;

  localparam int L = 2;

  typedef struct {
    int           grp;
    logic [127:0] data;
    int           busy_cycles;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy;
  silencer_settings_t            sil;
  sync_settings_t                sync_s;
  pulse_width_encoder_settings_t pwe;

  settings_loader_if bram_if ();

  settings_loader #(.BRAM_LATENCY(L)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .bram_if             (bram_if.master),
    .silencer_settings_o (sil),
    .sync_settings_o     (sync_s),
    .pwe_settings_o      (pwe),
    .busy_o              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: data read at ADDR appears L cycles later.
  logic [15:0] mem [256];
  logic [15:0] pipe [L];
  always @(posedge clk) begin
    if (bram_if.rd_en) pipe[0] <= mem[bram_if.addr];
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_if.rd_data = pipe[L-1];

  int vectors;
  int miscompares;
  int n_pushed;
  int n_popped;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input int g, input logic [127:0] d, input int b);
    exp_t e;
    e.grp = g;
    e.data = d;
    e.busy_cycles = b;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  function automatic logic [127:0] sil_bits(input silencer_settings_t s);
    return 128'(s[64:0]);
  endfunction
  function automatic logic [127:0] sync_bits(input sync_settings_t s);
    return 128'(s[95:0]);
  endfunction
  function automatic logic [127:0] pwe_bits(input pulse_width_encoder_settings_t s);
    return 128'(s[15:0]);
  endfunction

  // Monitor: pops the scoreboard on each UPDATE; fields may only change with their UPDATE.
  logic [127:0] prev_sil, prev_sync, prev_pwe, got_data;
  logic [2:0]   upd;
  int           busy_cnt;
  int           got_grp;
  exp_t         e_cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      upd = {pwe.update, sync_s.update, sil.update};
      if (upd != 3'b000) begin
        check("single_update", 128'($countones(upd)), 128'd1);
        got_grp  = upd[0] ? 0 : (upd[1] ? 1 : 2);
        got_data = (got_grp == 0) ? sil_bits(sil) : ((got_grp == 1) ? sync_bits(sync_s) : pwe_bits(pwe));
        if (exp_q.size() == 0) begin
          check("unexpected_update", 128'(upd), 128'd0);
        end else begin
          e_cur = exp_q.pop_front();
          n_popped++;
          check("update_group", 128'(got_grp), 128'(e_cur.grp));
          check("update_data", got_data, e_cur.data);
          check("busy_cycles", 128'(busy_cnt), 128'(e_cur.busy_cycles));
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
      if (!upd[0]) check("hold_silencer", sil_bits(sil), prev_sil);
      if (!upd[1]) check("hold_sync", sync_bits(sync_s), prev_sync);
      if (!upd[2]) check("hold_pwe", pwe_bits(pwe), prev_pwe);
    end
    prev_sil  = sil_bits(sil);
    prev_sync = sync_bits(sync_s);
    prev_pwe  = pwe_bits(pwe);
  end

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic wait_addr(input logic [7:0] a, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bram_if.rd_en && bram_if.addr == a) break;
    end
    check("wait_addr", 128'(i < budget), 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_silencer"}, 128'(sil), 128'd0);
    check({tag, "_sync"}, 128'(sync_s), 128'd0);
    check({tag, "_pwe"}, 128'(pwe), 128'd0);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_rd_en"}, 128'(bram_if.rd_en), 128'd0);
    check({tag, "_addr"}, 128'(bram_if.addr), 128'd0);
  endtask

  localparam logic [127:0] SIL_A  = 128'({1'b1, 16'h0100, 16'h0200, 16'd10, 16'd40});
  localparam logic [127:0] SIL_B  = 128'({1'b1, 16'h0AAA, 16'h0200, 16'd10, 16'd40});
  localparam logic [127:0] SIL_C  = 128'({1'b0, 16'h0AAA, 16'h0200, 16'd10, 16'd40});
  localparam logic [127:0] SIL_D  = 128'({1'b1, 16'h1111, 16'h0200, 16'd10, 16'd40});
  localparam logic [127:0] SYNC_A = 128'({32'h1234_5678, 64'h0000_1111_2222_3333});
  localparam logic [127:0] PWE_A  = 128'h0BEE;

  initial begin
    int polls;
    int last;
    vectors = 0;
    miscompares = 0;
    n_pushed = 0;
    n_popped = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: only flag polls, every 2+L cycles, always at address 0.
    polls = 0;
    last = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bram_if.rd_en) begin
        polls++;
        if (bram_if.addr != 8'h00) check("idle_addr", 128'(bram_if.addr), 128'd0);
        if (last >= 0 && i - last != 2 + L) check("idle_period", 128'(i - last), 128'(2 + L));
        last = i;
      end
    end
    check("idle_poll_count", 128'(polls >= 249 && polls <= 251), 128'd1);
    check("idle_outputs", sil_bits(sil) | sync_bits(sync_s) | pwe_bits(pwe), 128'd0);

    // Silencer load, repeated poll with flag unchanged, then toggle back.
    mem[8'h10] = 16'h0001; mem[8'h11] = 16'h0100; mem[8'h12] = 16'h0200;
    mem[8'h13] = 16'd10;   mem[8'h14] = 16'd40;
    push(0, SIL_A, 16);
    mem[8'h00] = 16'h0001;
    drain(200);
    repeat (60) @(negedge clk);
    mem[8'h11] = 16'h0AAA;
    push(0, SIL_B, 16);
    mem[8'h00] = 16'h0000;
    drain(200);

    // Sync word order.
    mem[8'h20] = 16'h5678; mem[8'h21] = 16'h1234; mem[8'h22] = 16'h3333;
    mem[8'h23] = 16'h2222; mem[8'h24] = 16'h1111; mem[8'h25] = 16'h0000;
    push(1, SYNC_A, 19);
    mem[8'h00] = 16'h0002;
    drain(200);

    // Priority: clear sync, then request all three in one write; MODE ignores bits 15:1.
    push(1, SYNC_A, 19);
    mem[8'h00] = 16'h0000;
    drain(200);
    mem[8'h10] = 16'hFFFE;
    mem[8'h30] = 16'h0BEE;
    push(0, SIL_C, 16);
    push(1, SYNC_A, 19);
    push(2, PWE_A, 4);
    mem[8'h00] = 16'h0007;
    drain(400);

    // Atomicity: 0x11 changes after it was read; outputs keep old values until commit.
    mem[8'h10] = 16'h0003;
    mem[8'h11] = 16'h1111;
    push(0, SIL_D, 16);
    mem[8'h00] = 16'h0006;
    wait_addr(8'h13, 200);
    mem[8'h11] = 16'h2222;
    check("atomic_old_values", sil_bits(sil), SIL_C);
    drain(200);

    // Mid-load reset during sync word 3.
    push(1, SYNC_A, 19);
    push(2, PWE_A, 4);
    mem[8'h00] = 16'h0000;
    drain(400);
    mem[8'h00] = 16'h0002;
    wait_addr(8'h23, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    repeat (3) @(negedge clk);
    push(1, SYNC_A, 19);
    rst_n = 1'b1;
    drain(200);
    repeat (100) @(negedge clk);

    check("update_total", 128'(n_popped), 128'(n_pushed));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/settings_loader.md
# settings_loader

Polls the controller parameter BRAM over its read port and assembles the silencer, sync and pulse-width-encoder settings structs consumed by the datapath. Host writes parameter words, then toggles a per-group request bit in a flag word. The loader detects the toggle, reads the group's words into shadow registers, and commits them atomically with a one-cycle UPDATE pulse. It is the producer end of the `settings` package interface.

## Interface
- BRAM_LATENCY, 2: cycles from ADDR issue to valid RD_DATA (1..4).
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- RD_EN  out  1  BRAM read enable, high in every ISSUE cycle.
- ADDR  out  8  BRAM word address.
- RD_DATA  in  16  BRAM read data, valid BRAM_LATENCY cycles after ADDR.
- SILENCER_SETTINGS  out  silencer_settings_t.
- SYNC_SETTINGS  out  sync_settings_t.
- PWE_SETTINGS  out  pulse_width_encoder_settings_t.
- BUSY  out  1  high while a group load is in progress (LOAD_ISSUE through COMMIT).

## Operation
- Word map (16-bit words, low word first):
  - 0x00: CTL_FLAG. bit0 silencer, bit1 sync, bit2 pwe.
  - 0x10: MODE (bit0). 0x11: UPDATE_RATE_INTENSITY. 0x12: UPDATE_RATE_PHASE. 0x13: COMPLETION_STEPS_INTENSITY. 0x14: COMPLETION_STEPS_PHASE.
  - 0x20..0x21: ECAT_SYNC_BASE_CNT. 0x22..0x25: ECAT_SYNC_TIME.
  - 0x30: FULL_WIDTH_START.
- Request semantics: a bit is pending when CTL_FLAG bit differs from the internal SEEN bit. SEEN resets to 0. SEEN[i] is set to the snapshot value only on commit of group i.
- Priority when several bits are pending: silencer > sync > pwe. One group per poll; the rest are served on later polls.
- FSM: POLL_ISSUE -> POLL_WAIT -> DECIDE -> (POLL_ISSUE | LOAD_ISSUE) ; LOAD_ISSUE -> LOAD_WAIT -> (LOAD_ISSUE next word | COMMIT) ; COMMIT -> POLL_ISSUE.
- POLL_ISSUE: ADDR=0x00.
- POLL_WAIT: lasts BRAM_LATENCY cycles; RD_DATA captured into the snapshot register in its last cycle.
- DECIDE: selects the group and its word counter (5 / 6 / 1 words).
- LOAD_WAIT captures RD_DATA into a shadow register indexed by the word counter.
- Shadow registers are never visible on outputs before COMMIT; outputs change only at commit.
- COMMIT: the edge leaving COMMIT loads all fields of the selected group from shadow and sets that group's UPDATE=1. UPDATE clears on the next edge (exactly one-cycle pulse).
- UPDATE of other groups stays 0. Untouched fields hold their values indefinitely.
- Width rules:
  - MODE = word bit0; bits 15:1 ignored.
  - 32/64-bit fields concatenate words with the lowest address as LSW.
  - 16-bit fields are copied verbatim.
- A bit toggled twice between snapshots is invisible (no load); this is intended.
- Parameter words are sampled as read. Writes racing a load are the host's responsibility.

## Timing
- Reset: all outputs 0; all struct fields 0; UPDATE 0; RD_EN 0; ADDR 0x00; BUSY 0; SEEN 0; FSM POLL_ISSUE.
- Reset is asynchronous at any state. A partial shadow is discarded, no UPDATE is issued, and SEEN reverts to 0.
- Poll period with no request: 1 + L + 1 cycles (L = BRAM_LATENCY); 4 cycles at L=2.
- Per loaded word: 1 + L cycles, one word outstanding at a time.
- Detection to UPDATE, counted from the DECIDE cycle (L=2):
  - silencer: 1 + 5·3 + 1 = 17 edges.
  - sync: 20 edges.
  - pwe: 5 edges.
- RD_EN is high exactly in POLL_ISSUE and LOAD_ISSUE cycles. ADDR holds its value until the next ISSUE.
- BUSY rises on the edge entering LOAD_ISSUE and falls on the edge leaving COMMIT, coincident with UPDATE rising.

## Test plan
- Reset, BRAM all zero -> no UPDATE over 1000 cycles; outputs 0; RD_EN pulses every 4 cycles at ADDR 0x00.
- Silencer: preload 0x10..0x14 = 1, 0x0100, 0x0200, 10, 40; set CTL_FLAG=0x0001 -> one SILENCER UPDATE pulse with MODE=1, rates 0x0100 / 0x0200, steps 10 / 40, 17 edges after DECIDE. A repeated poll with the flag still 1 -> no further pulse. Flag back to 0 -> second load and pulse.
- Sync word order: 0x20..0x25 = 0x5678, 0x1234, 0x3333, 0x2222, 0x1111, 0x0000 -> ECAT_SYNC_BASE_CNT=0x12345678, ECAT_SYNC_TIME=0x0000111122223333, single SYNC UPDATE.
- Priority: CTL_FLAG=0x0007 in one write -> UPDATE order silencer, then sync, then pwe, on three consecutive load passes; never two UPDATEs in the same cycle.
- Atomicity: change 0x11 while in LOAD_WAIT of word 0x13 -> outputs show old values until commit; the committed value equals the word read; no field changes without UPDATE.
- Mid-load reset: assert RST_N=0 during sync word 3 -> all outputs 0 immediately; after release with CTL_FLAG=0x0002 still set -> full sync reload and exactly one UPDATE.
